// File: rtl/vscale_lsu_if.sv
// Bundle of pipeline request/response and data-memory channel signals for vscale_lsu.
// The slave modport is the LSU's view; master is the view of whatever drives it.
interface vscale_lsu_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [2:0]        req_type;
    logic [XLEN-1:0]   req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic [TAG_W-1:0]  req_tag;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_wen;
    logic [XLEN-1:0]   mem_req_addr;
    logic [XLEN-1:0]   mem_req_wdata;
    logic [XLEN/8-1:0] mem_req_wmask;
    logic              mem_resp_valid;
    logic [XLEN-1:0]   mem_resp_rdata;
    logic              mem_resp_err;

    logic              resp_valid;
    logic [XLEN-1:0]   resp_data;
    logic [TAG_W-1:0]  resp_tag;
    logic              resp_wen;
    logic [1:0]        resp_err;
    logic              unexp_resp;

    modport slave (
        input  req_valid, req_wen, req_type, req_addr, req_wdata, req_tag,
        output req_ready,
        output mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err,
        output resp_valid, resp_data, resp_tag, resp_wen, resp_err, unexp_resp
    );

    modport master (
        output req_valid, req_wen, req_type, req_addr, req_wdata, req_tag,
        input  req_ready,
        input  mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err,
        input  resp_valid, resp_data, resp_tag, resp_wen, resp_err, unexp_resp
    );
endinterface

// File: rtl/vscale_lsu.sv
// Load/store unit: issues aligned accesses to data memory, tracks up to DEPTH in-flight
// requests in program order and returns extended load data / store acks with fault status.
module vscale_lsu #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input  logic        clk,
    input  logic        reset,
    vscale_lsu_if.slave bus
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Sizes that do not exist at this XLEN are folded into the misaligned path.
    function automatic logic f_misal(input logic [2:0] typ, input logic [2:0] lo);
        logic m;
        m = 1'b1;
        case (typ)
            3'd0, 3'd4: m = 1'b0;
            3'd1, 3'd5: m = lo[0];
            3'd2:       m = |lo[1:0];
            3'd3:       m = (XLEN == 64) ? |lo[2:0] : 1'b1;
            3'd6:       m = (XLEN == 64) ? |lo[1:0] : 1'b1;
            default:    m = 1'b1;
        endcase
        return m;
    endfunction

    function automatic logic [XLEN-1:0] f_wdata(input logic [1:0] sz, input logic [XLEN-1:0] d);
        logic [XLEN-1:0] r;
        case (sz)
            2'd0:    r = {NB{d[7:0]}};
            2'd1:    r = {(NB/2){d[15:0]}};
            2'd2:    r = {(XLEN/32){d[31:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [NB-1:0] f_wmask(input logic [1:0] sz, input logic [OFF_W-1:0] lo);
        logic [NB-1:0] base;
        case (sz)
            2'd0:    base = NB'(1);
            2'd1:    base = NB'(3);
            2'd2:    base = NB'(15);
            default: base = '1;
        endcase
        return base << lo;
    endfunction

    function automatic logic [XLEN-1:0] f_extend(input logic [2:0] typ, input logic [OFF_W-1:0] lo,
                                                 input logic [XLEN-1:0] rdata);
        logic [XLEN-1:0] sh;
        logic [XLEN-1:0] r;
        logic            s;
        int              w;
        sh = rdata >> {lo, 3'b000};
        r  = '0;
        case (typ[1:0])
            2'd0:    begin w = 8;    s = sh[7];      end
            2'd1:    begin w = 16;   s = sh[15];     end
            2'd2:    begin w = 32;   s = sh[31];     end
            default: begin w = XLEN; s = sh[XLEN-1]; end
        endcase
        for (int i = 0; i < XLEN; i++) begin
            r[i] = (i < w) ? sh[i] : (s & ~typ[2]);
        end
        return r;
    endfunction

    logic [DEPTH-1:0]  r_q_wen;
    logic [DEPTH-1:0]  r_q_misal;
    logic [2:0]        r_q_type [DEPTH];
    logic [OFF_W-1:0]  r_q_lo   [DEPTH];
    logic [TAG_W-1:0]  r_q_tag  [DEPTH];

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              r_resp_valid;
    logic [XLEN-1:0]   r_resp_data;
    logic [TAG_W-1:0]  r_resp_tag;
    logic              r_resp_wen;
    logic [1:0]        r_resp_err;
    logic              r_unexp;

    logic              w_full;
    logic              w_empty;
    logic              w_req_misal;
    logic              w_push;
    logic              w_head_misal;
    logic              w_pop;
    logic              w_unexp;
    logic [XLEN-1:0]   w_resp_data;
    logic [1:0]        w_resp_err;

    assign w_full      = (r_count == CNT_W'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_req_misal = f_misal(bus.req_type, bus.req_addr[2:0]);

    // Misaligned requests never touch memory, so they do not wait on mem_req_ready.
    assign bus.req_ready     = !w_full && (w_req_misal || bus.mem_req_ready);
    assign bus.mem_req_valid = bus.req_valid && !w_req_misal && !w_full;
    assign bus.mem_req_wen   = bus.req_wen;
    assign bus.mem_req_addr  = {bus.req_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
    assign bus.mem_req_wdata = f_wdata(bus.req_type[1:0], bus.req_wdata);
    assign bus.mem_req_wmask = f_wmask(bus.req_type[1:0], bus.req_addr[OFF_W-1:0]);

    assign w_push = bus.req_valid && bus.req_ready;

    // A misaligned head retires on its own; a memory response arriving then has no owner.
    assign w_head_misal = !w_empty && r_q_misal[r_rd_ptr];
    assign w_pop        = w_head_misal || (!w_empty && bus.mem_resp_valid);
    assign w_unexp      = bus.mem_resp_valid && (w_empty || r_q_misal[r_rd_ptr]);

    assign w_resp_err  = w_head_misal ? 2'b01 : (bus.mem_resp_err ? 2'b10 : 2'b00);
    assign w_resp_data = (w_head_misal || bus.mem_resp_err || r_q_wen[r_rd_ptr]) ? '0 :
                         f_extend(r_q_type[r_rd_ptr], r_q_lo[r_rd_ptr], bus.mem_resp_rdata);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_wen[r_wr_ptr]   <= bus.req_wen;
            r_q_misal[r_wr_ptr] <= w_req_misal;
            r_q_type[r_wr_ptr]  <= bus.req_type;
            r_q_lo[r_wr_ptr]    <= bus.req_addr[OFF_W-1:0];
            r_q_tag[r_wr_ptr]   <= bus.req_tag;
        end
    end

    // Response stage: one registered cycle after the pop decision.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_tag   <= '0;
            r_resp_wen   <= 1'b0;
            r_resp_err   <= 2'b00;
            r_unexp      <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count      <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            r_resp_valid <= w_pop;
            if (w_pop) begin
                r_resp_data <= w_resp_data;
                r_resp_tag  <= r_q_tag[r_rd_ptr];
                r_resp_wen  <= r_q_wen[r_rd_ptr];
                r_resp_err  <= w_resp_err;
            end
            if (w_unexp) begin
                r_unexp <= 1'b1;
            end
        end
    end

    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_data  = r_resp_data;
    assign bus.resp_tag   = r_resp_tag;
    assign bus.resp_wen   = r_resp_wen;
    assign bus.resp_err   = r_resp_err;
    assign bus.unexp_resp = r_unexp;
endmodule

// File: tb/tb_vscale_lsu.sv
// Directed bench for vscale_lsu at XLEN=32 and XLEN=64 with queue-based response scoreboards.
module tb_vscale_lsu;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vscale_lsu_if #(.XLEN(32), .TAG_W(5)) b32 ();
    vscale_lsu_if #(.XLEN(64), .TAG_W(5)) b64 ();

    vscale_lsu #(.XLEN(32), .DEPTH(4), .TAG_W(5)) u_dut32 (.clk(clk), .reset(reset), .bus(b32));
    vscale_lsu #(.XLEN(64), .DEPTH(4), .TAG_W(5)) u_dut64 (.clk(clk), .reset(reset), .bus(b64));

    typedef struct {
        logic [63:0] data;
        logic [4:0]  tag;
        logic        wen;
        logic [1:0]  err;
    } exp_t;

    exp_t sb32[$];
    exp_t sb64[$];
    exp_t e32;
    exp_t e64;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic push32(input logic [63:0] d, input logic [4:0] t, input logic w, input logic [1:0] e);
        exp_t x;
        x.data = d; x.tag = t; x.wen = w; x.err = e;
        sb32.push_back(x);
    endtask

    task automatic push64(input logic [63:0] d, input logic [4:0] t, input logic w, input logic [1:0] e);
        exp_t x;
        x.data = d; x.tag = t; x.wen = w; x.err = e;
        sb64.push_back(x);
    endtask

    task automatic drv32(input logic w, input logic [2:0] ty, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] t);
        b32.req_valid = 1'b1; b32.req_wen = w; b32.req_type = ty;
        b32.req_addr = a; b32.req_wdata = wd; b32.req_tag = t;
    endtask

    task automatic drv64(input logic w, input logic [2:0] ty, input logic [63:0] a,
                         input logic [63:0] wd, input logic [4:0] t);
        b64.req_valid = 1'b1; b64.req_wen = w; b64.req_type = ty;
        b64.req_addr = a; b64.req_wdata = wd; b64.req_tag = t;
    endtask

    task automatic mresp32(input logic [31:0] rd, input logic er);
        b32.mem_resp_valid = 1'b1; b32.mem_resp_rdata = rd; b32.mem_resp_err = er;
    endtask

    task automatic mresp64(input logic [63:0] rd, input logic er);
        b64.mem_resp_valid = 1'b1; b64.mem_resp_rdata = rd; b64.mem_resp_err = er;
    endtask

    // Monitors: every response pulse is matched against the oldest expected entry.
    always @(negedge clk) begin
        if (b32.resp_valid === 1'b1) begin
            if (sb32.size() == 0) begin
                checks++; errors++;
                $display("FAIL resp32_unexpected: got tag %0d expected no response", b32.resp_tag);
            end else begin
                e32 = sb32.pop_front();
                chk("resp32_data", 64'(b32.resp_data), e32.data);
                chk("resp32_tag", 64'(b32.resp_tag), 64'(e32.tag));
                chk("resp32_wen", 64'(b32.resp_wen), 64'(e32.wen));
                chk("resp32_err", 64'(b32.resp_err), 64'(e32.err));
            end
        end
    end

    always @(negedge clk) begin
        if (b64.resp_valid === 1'b1) begin
            if (sb64.size() == 0) begin
                checks++; errors++;
                $display("FAIL resp64_unexpected: got tag %0d expected no response", b64.resp_tag);
            end else begin
                e64 = sb64.pop_front();
                chk("resp64_data", b64.resp_data, e64.data);
                chk("resp64_tag", 64'(b64.resp_tag), 64'(e64.tag));
                chk("resp64_wen", 64'(b64.resp_wen), 64'(e64.wen));
                chk("resp64_err", 64'(b64.resp_err), 64'(e64.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        b32.req_valid = 0; b32.req_wen = 0; b32.req_type = 0; b32.req_addr = 0;
        b32.req_wdata = 0; b32.req_tag = 0; b32.mem_req_ready = 0;
        b32.mem_resp_valid = 0; b32.mem_resp_rdata = 0; b32.mem_resp_err = 0;
        b64.req_valid = 0; b64.req_wen = 0; b64.req_type = 0; b64.req_addr = 0;
        b64.req_wdata = 0; b64.req_tag = 0; b64.mem_req_ready = 0;
        b64.mem_resp_valid = 0; b64.mem_resp_rdata = 0; b64.mem_resp_err = 0;
        repeat (3) cyc();

        chk("rst_resp_valid", 64'(b32.resp_valid), 0);
        chk("rst_resp_data", 64'(b32.resp_data), 0);
        chk("rst_resp_tag", 64'(b32.resp_tag), 0);
        chk("rst_resp_wen", 64'(b32.resp_wen), 0);
        chk("rst_resp_err", 64'(b32.resp_err), 0);
        chk("rst_unexp", 64'(b32.unexp_resp), 0);
        chk("rst64_resp_valid", 64'(b64.resp_valid), 0);

        reset = 1'b0;
        b32.mem_req_ready = 1'b1;
        b64.mem_req_ready = 1'b1;

        // LB 0x103, sign-extended byte from lane 3
        drv32(0, 3'd0, 32'h103, 32'h0, 5'd1);
        #1;
        chk("lb_req_ready", 64'(b32.req_ready), 1);
        chk("lb_mem_valid", 64'(b32.mem_req_valid), 1);
        chk("lb_mem_addr", 64'(b32.mem_req_addr), 64'h100);
        chk("lb_mem_wen", 64'(b32.mem_req_wen), 0);
        push32(64'hFFFF_FF80, 5'd1, 1'b0, 2'b00);
        cyc();
        b32.req_valid = 0;
        mresp32(32'h80FF_0000, 1'b0);
        cyc();
        b32.mem_resp_valid = 0;
        chk("lb_latency", 64'(b32.resp_valid), 1);

        // SH 0x102: halfword replicated, upper two byte lanes enabled
        drv32(1, 3'd1, 32'h102, 32'h1234_ABCD, 5'd2);
        #1;
        chk("sh_mem_valid", 64'(b32.mem_req_valid), 1);
        chk("sh_wdata", 64'(b32.mem_req_wdata), 64'hABCD_ABCD);
        chk("sh_wmask", 64'(b32.mem_req_wmask), 64'b1100);
        chk("sh_addr", 64'(b32.mem_req_addr), 64'h100);
        chk("sh_wen", 64'(b32.mem_req_wen), 1);
        push32(64'h0, 5'd2, 1'b1, 2'b00);
        cyc();
        b32.req_valid = 0;
        mresp32(32'h0, 1'b0);
        cyc();
        b32.mem_resp_valid = 0;

        // Pipelined loads: access fault, LHU, LH, LW with overlapping push/pop
        drv32(0, 3'd1, 32'h100, 32'h0, 5'd3);
        push32(64'h0, 5'd3, 1'b0, 2'b10);
        cyc();
        drv32(0, 3'd5, 32'h102, 32'h0, 5'd4);
        push32(64'h0000_BEEF, 5'd4, 1'b0, 2'b00);
        mresp32(32'hDEAD_BEEF, 1'b1);
        cyc();
        drv32(0, 3'd1, 32'h102, 32'h0, 5'd5);
        push32(64'hFFFF_BEEF, 5'd5, 1'b0, 2'b00);
        mresp32(32'hBEEF_1234, 1'b0);
        cyc();
        drv32(0, 3'd2, 32'h0, 32'h0, 5'd6);
        push32(64'h8765_4321, 5'd6, 1'b0, 2'b00);
        mresp32(32'hBEEF_1234, 1'b0);
        cyc();
        b32.req_valid = 0;
        mresp32(32'h8765_4321, 1'b0);
        cyc();
        b32.mem_resp_valid = 0;
        cyc();

        // Misaligned LW queued behind two outstanding loads
        drv32(0, 3'd2, 32'h200, 32'h0, 5'd7);
        push32(64'h1122_3344, 5'd7, 1'b0, 2'b00);
        cyc();
        drv32(0, 3'd4, 32'h201, 32'h0, 5'd8);
        push32(64'hAB, 5'd8, 1'b0, 2'b00);
        cyc();
        drv32(0, 3'd2, 32'h101, 32'h0, 5'd9);
        #1;
        chk("mis_mem_valid", 64'(b32.mem_req_valid), 0);
        chk("mis_req_ready", 64'(b32.req_ready), 1);
        push32(64'h0, 5'd9, 1'b0, 2'b01);
        cyc();
        b32.req_valid = 0;
        cyc();
        chk("mis_wait", 64'(b32.resp_valid), 0);
        mresp32(32'h1122_3344, 1'b0);
        cyc();
        mresp32(32'h0000_AB00, 1'b0);
        cyc();
        b32.mem_resp_valid = 0;
        cyc();
        chk("mis_resp_valid", 64'(b32.resp_valid), 1);
        chk("mis_resp_err", 64'(b32.resp_err), 64'b01);
        cyc();

        // Full queue: four accepted, fifth blocked until a pop lands
        for (int k = 0; k < 4; k++) begin
            drv32(0, 3'd2, 32'h300 + 32'(4 * k), 32'h0, 5'(10 + k));
            #1;
            chk("full_accept", 64'(b32.req_ready), 1);
            push32(64'hA0 + 64'(k), 5'(10 + k), 1'b0, 2'b00);
            cyc();
        end
        drv32(0, 3'd2, 32'h310, 32'h0, 5'd14);
        #1;
        chk("full_block", 64'(b32.req_ready), 0);
        chk("full_no_mem", 64'(b32.mem_req_valid), 0);
        cyc();
        #1;
        chk("full_block2", 64'(b32.req_ready), 0);
        mresp32(32'hA0, 1'b0);
        #1;
        chk("full_pop_ready", 64'(b32.req_ready), 0);
        cyc();
        chk("full_reopen", 64'(b32.req_ready), 1);
        push32(64'hA4, 5'd14, 1'b0, 2'b00);
        mresp32(32'hA1, 1'b0);
        cyc();
        b32.req_valid = 0;
        mresp32(32'hA2, 1'b0);
        cyc();
        mresp32(32'hA3, 1'b0);
        cyc();
        mresp32(32'hA4, 1'b0);
        cyc();
        b32.mem_resp_valid = 0;
        cyc();

        // Misaligned head coinciding with a stray memory response
        chk("unexp_clear", 64'(b32.unexp_resp), 0);
        drv32(0, 3'd1, 32'h101, 32'h0, 5'd15);
        push32(64'h0, 5'd15, 1'b0, 2'b01);
        cyc();
        b32.req_valid = 0;
        mresp32(32'h0000_FFFF, 1'b0);
        cyc();
        b32.mem_resp_valid = 0;
        chk("misal_unexp_err", 64'(b32.resp_err), 64'b01);
        chk("misal_unexp_set", 64'(b32.unexp_resp), 1);
        cyc();

        // Reset with three loads in flight discards them
        for (int k = 0; k < 3; k++) begin
            drv32(0, 3'd2, 32'h400 + 32'(4 * k), 32'h0, 5'(20 + k));
            cyc();
        end
        b32.req_valid = 0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("rst2_unexp", 64'(b32.unexp_resp), 0);
        chk("rst2_resp_valid", 64'(b32.resp_valid), 0);
        mresp32(32'h55, 1'b0);
        cyc();
        b32.mem_resp_valid = 0;
        chk("rst2_no_resp", 64'(b32.resp_valid), 0);
        chk("rst2_unexp_set", 64'(b32.unexp_resp), 1);
        cyc();

        // XLEN=64: LWU upper word, SB lane 5, LD
        drv64(0, 3'd6, 64'h4, 64'h0, 5'd1);
        #1;
        chk("lwu_mem_valid", 64'(b64.mem_req_valid), 1);
        chk("lwu_mem_addr", b64.mem_req_addr, 64'h0);
        push64(64'h0000_0000_8000_0001, 5'd1, 1'b0, 2'b00);
        cyc();
        b64.req_valid = 0;
        mresp64(64'h8000_0001_DEAD_BEEF, 1'b0);
        cyc();
        b64.mem_resp_valid = 0;
        drv64(1, 3'd0, 64'h5, 64'hAA, 5'd2);
        #1;
        chk("sb64_wdata", b64.mem_req_wdata, 64'hAAAA_AAAA_AAAA_AAAA);
        chk("sb64_wmask", 64'(b64.mem_req_wmask), 64'h20);
        push64(64'h0, 5'd2, 1'b1, 2'b00);
        cyc();
        drv64(0, 3'd3, 64'h8, 64'h0, 5'd3);
        #1;
        chk("ld64_addr", b64.mem_req_addr, 64'h8);
        push64(64'hFEDC_BA98_7654_3210, 5'd3, 1'b0, 2'b00);
        mresp64(64'h0, 1'b0);
        cyc();
        b64.req_valid = 0;
        mresp64(64'hFEDC_BA98_7654_3210, 1'b0);
        cyc();
        b64.mem_resp_valid = 0;

        repeat (3) cyc();
        chk("sb32_drained", 64'(sb32.size()), 0);
        chk("sb64_drained", 64'(sb64.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
